ex_result_stage: RTL and testbench
==================================

Name: ex_result_stage

Overview:
- Execute-stage back end, directly downstream of the combinational ALU.
- Captures the ALU result, destination register and writeback enable into a 2-entry skid buffer with a valid/ready handshake toward the memory/writeback stage.
- Holds the architectural NZCV flag register, updated from the ALU flag outputs.
- Evaluates a 4-bit branch condition against the registered flags.

Parameters:
- N, 32, datapath width; must match the ALU.
- RW, 4, destination register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  stage can accept.
- resultado  input  N  ALU result.
- cout, zero, neg, overflow  input  1 each  ALU flags.
- aluControl  input  3  opcode that produced resultado.
- rd  input  RW  destination register.
- we  input  1  instruction writes rd.
- set_flags  input  1  instruction updates NZCV.
- flush  input  1  synchronous pipeline flush.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts.
- out_result  output  N  head result.
- out_rd  output  RW  head destination.
- out_we  output  1  head writeback enable.
- flags  output  4  registered {N,Z,C,V}.
- cond  input  4  branch condition code.
- cond_true  output  1  condition holds on registered flags.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - count=0, out_valid=0, in_ready=1.
  - out_result=0, out_rd=0, out_we=0.
  - flags=4'b0000.
- Storage: 2-entry FIFO (head/tail pointers 1 bit each, count 0..2). Entry = {result, rd, we_eff}.
- Write enable: we_eff = we & (aluControl != 3'b111). Compare never writes a register but is still pushed, preserving order.
- in_ready = (count < 2) & ~flush, combinational from registered count. accept = in_valid & in_ready.
- out_valid = (count != 0). out_* driven from the head entry, zero when empty. pop = out_valid & out_ready.
- Buffer transitions:
  - accept only: write at tail, tail++, count++.
  - pop only: head++, count--.
  - accept and pop together (count 1): count unchanged, both pointers advance.
  - At count 0, an accepted entry appears on out_* the next cycle. Latency 1, no bypass.
  - At count 2, in_ready=0, so a same-cycle pop frees a slot visible next cycle. No combinational ready path from out_ready to in_ready.
  - Pointers wrap modulo 2.
- Downstream stall: while out_valid=1 and out_ready=0, out_* are held stable.
- Flag update: on accept with set_flags=1 and aluControl in {000,001,010,011,100,111}, flags <= {neg,zero,cout,overflow} at the next edge. Otherwise flags hold. 101 (shift) and 110 (pass-b) never update flags.
- Flush: next edge count=0, pointers=0, out_valid=0. The same-cycle in_valid is dropped and flags are not updated. Flags written by previously accepted ops are retained.
- Reset mid-operation: all state clears immediately and asynchronously; in-flight entries are lost.
- cond_true is combinational from registered flags only; flags from an op accepted this cycle are visible next cycle. Codes:
  - 0 EQ: Z.
  - 1 NE: !Z.
  - 2 CS: C.
  - 3 CC: !C.
  - 4 MI: N.
  - 5 PL: !N.
  - 6 VS: V.
  - 7 VC: !V.
  - 8 HI: C&!Z.
  - 9 LS: !C|Z.
  - A GE: N==V.
  - B LT: N!=V.
  - C GT: !Z&(N==V).
  - D LE: Z|(N!=V).
  - E AL: 1.
  - F NV: 0.
- Widths: no arithmetic on data; result stored verbatim, N bits.

Test Plan:
- Reset, then a single push of resultado=0x0000_0005, rd=3, we=1, aluControl=000, out_ready=1 -> out_valid=1 one cycle later with out_result=5, out_rd=3, out_we=1; count back to 0 the cycle after.
- Hold out_ready=0 and push 0x11, 0x22, 0x33 on consecutive cycles -> in_ready drops after two accepts, 0x33 is held off; raising out_ready drains 0x11 then 0x22 in order, then 0x33 is accepted.
- aluControl=111, set_flags=1, zero=1, neg=0, cout=1, we=1 -> out_we=0; flags=4'b0110 next cycle; cond=0 gives cond_true=1 and cond=8 gives 0.
- aluControl=101, set_flags=1 with flags previously 4'b1001 -> flags remain 1001; cond=A gives cond_true=1.
- Buffer holding 2 entries, assert flush with in_valid=1 and set_flags=1 -> out_valid=0 next cycle, flags unchanged, the flushed input is absent from the output.
- Drive rst_n low asynchronously mid-stream with count=2 -> out_valid=0 and flags=0 immediately, without a clock edge.

Source files
------------

// File: rtl/ex_result_stage.sv
// ex_result_stage
// Execute-stage back end sitting right after the combinational ALU.
//   - Captures {result, rd, write enable} into a 2-entry skid buffer and
//     presents the oldest entry to the memory/writeback stage.
//   - Holds the architectural NZCV flag register, loaded from the ALU flags.
//   - Evaluates a 4-bit branch condition against the registered flags.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until the
// transfer. in_ready depends only on registered state (never on out_ready),
// and out_* are held stable while out_valid=1 and out_ready=0.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid / in_ready           upstream handshake
//   resultado, cout, zero, neg,
//   overflow, aluControl          ALU result, flags and opcode
//   rd, we, set_flags             destination, write enable, flag update
//   flush                         synchronous pipeline flush
//   out_valid / out_ready         downstream handshake
//   out_result, out_rd, out_we    head entry (zero when empty)
//   flags                         registered {N,Z,C,V}
//   cond / cond_true              branch condition code and its outcome
module ex_result_stage #(
   parameter int N  = 32,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  resultado,
   input  logic          cout,
   input  logic          zero,
   input  logic          neg,
   input  logic          overflow,
   input  logic [2:0]    aluControl,
   input  logic [RW-1:0] rd,
   input  logic          we,
   input  logic          set_flags,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_result,
   output logic [RW-1:0] out_rd,
   output logic          out_we,
   output logic [3:0]    flags,
   input  logic [3:0]    cond,
   output logic          cond_true
);

   logic [N-1:0]  mem_result [2];
   logic [RW-1:0] mem_rd     [2];
   logic [1:0]    mem_we;
   logic          head;
   logic          tail;
   logic [1:0]    count;
   logic [3:0]    flags_q;

   logic accept;
   logic pop;
   logic we_eff;
   logic flag_upd;

   // Compare (111) is still pushed to keep ordering but never writes rd.
   assign we_eff    = we & (aluControl != 3'b111);
   assign in_ready  = (count < 2'd2) & ~flush;
   assign accept    = in_valid & in_ready;
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid & out_ready;

   // Shift (101) and pass-b (110) leave the flags alone. accept already
   // excludes flush, so a flushed op cannot touch the flags.
   assign flag_upd  = accept & set_flags &
                      (aluControl != 3'b101) & (aluControl != 3'b110);

   assign out_result = out_valid ? mem_result[head] : '0;
   assign out_rd     = out_valid ? mem_rd[head]     : '0;
   assign out_we     = out_valid ? mem_we[head]     : 1'b0;
   assign flags      = flags_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head          <= 1'b0;
         tail          <= 1'b0;
         count         <= 2'd0;
         mem_result[0] <= '0;
         mem_result[1] <= '0;
         mem_rd[0]     <= '0;
         mem_rd[1]     <= '0;
         mem_we        <= 2'b00;
      end else if (flush) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (accept) begin
            mem_result[tail] <= resultado;
            mem_rd[tail]     <= rd;
            mem_we[tail]     <= we_eff;
            tail             <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({accept, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
      end else if (flag_upd) begin
         flags_q <= {neg, zero, cout, overflow};
      end
   end

   // Condition evaluation on registered flags only.
   logic f_n, f_z, f_c, f_v;
   assign {f_n, f_z, f_c, f_v} = flags_q;

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'h0: cond_true = f_z;
         4'h1: cond_true = ~f_z;
         4'h2: cond_true = f_c;
         4'h3: cond_true = ~f_c;
         4'h4: cond_true = f_n;
         4'h5: cond_true = ~f_n;
         4'h6: cond_true = f_v;
         4'h7: cond_true = ~f_v;
         4'h8: cond_true = f_c & ~f_z;
         4'h9: cond_true = ~f_c | f_z;
         4'hA: cond_true = (f_n == f_v);
         4'hB: cond_true = (f_n != f_v);
         4'hC: cond_true = ~f_z & (f_n == f_v);
         4'hD: cond_true = f_z | (f_n != f_v);
         4'hE: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ex_result_stage.sv
module tb_ex_result_stage;
   localparam int N  = 32;
   localparam int RW = 4;
   localparam int EW = N + RW + 1;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid = 0, in_ready;
   logic [N-1:0]  resultado = '0;
   logic          cout = 0, zero = 0, neg = 0, overflow = 0;
   logic [2:0]    aluControl = '0;
   logic [RW-1:0] rd = '0;
   logic          we = 0, set_flags = 0, flush = 0;
   logic          out_valid, out_ready = 0;
   logic [N-1:0]  out_result;
   logic [RW-1:0] out_rd;
   logic          out_we;
   logic [3:0]    flags;
   logic [3:0]    cond = '0;
   logic          cond_true;

   ex_result_stage #(.N(N), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .resultado(resultado), .cout(cout), .zero(zero), .neg(neg),
      .overflow(overflow), .aluControl(aluControl), .rd(rd), .we(we),
      .set_flags(set_flags), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
      .flags(flags), .cond(cond), .cond_true(cond_true)
   );

   // scoreboard / reference model
   logic [EW-1:0] exp_q[$];
   logic [3:0]    m_flags = 4'b0000;
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Architectural condition meaning, stated from the flag semantics.
   function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      bit base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;                    // EQ / NE
         3'd1: base = cy;                   // CS / CC
         3'd2: base = n;                    // MI / PL
         3'd3: base = v;                    // VS / VC
         3'd4: base = cy && !z;             // HI / LS
         3'd5: base = (n == v);             // GE / LT
         3'd6: base = !z && (n == v);       // GT / LE
         default: base = 1'b1;              // AL / NV
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic check_outputs();
      logic [EW-1:0] h;
      bit has;
      has = exp_q.size() != 0;
      h = has ? exp_q[0] : '0;
      check("in_ready",   in_ready,   (exp_q.size() < 2) && !flush);
      check("out_valid",  out_valid,  has);
      check("out_result", out_result, h[EW-1 -: N]);
      check("out_rd",     out_rd,     h[RW:1]);
      check("out_we",     out_we,     h[0]);
      check("flags",      flags,      m_flags);
      check("cond_true",  cond_true,  ref_cond(cond, m_flags));
   endtask

   task automatic model_update();
      bit acc, pp;
      acc = in_valid && (exp_q.size() < 2) && !flush;
      pp  = (exp_q.size() != 0) && out_ready;
      if (flush) begin
         exp_q.delete();
      end else begin
         if (pp) void'(exp_q.pop_front());
         if (acc) exp_q.push_back({resultado, rd, we && (aluControl != 3'd7)});
      end
      if (acc && set_flags && aluControl != 3'd5 && aluControl != 3'd6)
         m_flags = {neg, zero, cout, overflow};
   endtask

   // One cycle: inputs already driven; sample at negedge, then advance.
   task automatic step();
      @(negedge clk);
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [N-1:0] res, input logic [RW-1:0] r,
                             input logic w, input logic [2:0] op, input logic sf,
                             input logic [3:0] nzcv);
      in_valid = 1; resultado = res; rd = r; we = w; aluControl = op;
      set_flags = sf; {neg, zero, cout, overflow} = nzcv;
   endtask

   initial begin
      // reset state
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready",  in_ready,  1);
      check("rst_flags",     flags,     0);
      check("rst_out_result", out_result, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;

      // single push, latency 1
      out_ready = 1;
      drive_push(32'h5, 4'd3, 1, 3'b000, 0, 4'b0000);
      step();
      in_valid = 0;
      check("t1_valid", out_valid, 1);
      check("t1_result", out_result, 32'h5);
      check("t1_rd", out_rd, 4'd3);
      check("t1_we", out_we, 1);
      step();
      check("t1_empty", out_valid, 0);

      // fill with downstream stalled
      out_ready = 0;
      drive_push(32'h11, 4'd1, 1, 3'b000, 0, 4'b0000); step();
      drive_push(32'h22, 4'd2, 1, 3'b000, 0, 4'b0000); step();
      drive_push(32'h33, 4'd3, 1, 3'b000, 0, 4'b0000);
      check("t2_full_ready", in_ready, 0);
      step();
      check("t2_hold_head", out_result, 32'h11);
      out_ready = 1;
      step();
      check("t2_second", out_result, 32'h22);
      step();
      in_valid = 0;
      check("t2_third", out_result, 32'h33);
      step();
      step();

      // compare: no writeback, flags loaded
      drive_push(32'h0, 4'd7, 1, 3'b111, 1, 4'b0110);
      step();
      in_valid = 0;
      check("t3_we", out_we, 0);
      check("t3_flags", flags, 4'b0110);
      cond = 4'h0; #1; check("t3_eq", cond_true, 1);
      cond = 4'h8; #1; check("t3_hi", cond_true, 0);
      step();

      // shift does not touch flags
      drive_push(32'h1, 4'd1, 1, 3'b000, 1, 4'b1001); step();
      drive_push(32'h2, 4'd2, 1, 3'b101, 1, 4'b0110); step();
      in_valid = 0;
      check("t4_flags", flags, 4'b1001);
      cond = 4'hA; #1; check("t4_ge", cond_true, 1);
      step(); step();

      // flush with two entries buffered
      out_ready = 0;
      drive_push(32'hA1, 4'd1, 1, 3'b000, 0, 4'b0000); step();
      drive_push(32'hA2, 4'd2, 1, 3'b000, 0, 4'b0000); step();
      drive_push(32'hA3, 4'd3, 1, 3'b000, 1, 4'b0100);
      flush = 1;
      step();
      flush = 0; in_valid = 0;
      check("t5_valid", out_valid, 0);
      check("t5_flags", flags, 4'b1001);
      step();

      // asynchronous reset with a full buffer
      drive_push(32'hB1, 4'd1, 1, 3'b000, 0, 4'b0000); step();
      drive_push(32'hB2, 4'd2, 1, 3'b000, 0, 4'b0000); step();
      in_valid = 0;
      check("t6_full", out_valid, 1);
      #3 rst_n = 0;
      #1;
      check("t6_valid", out_valid, 0);
      check("t6_flags", flags, 0);
      check("t6_ready", in_ready, 1);
      exp_q.delete();
      m_flags = 4'b0000;
      #2 rst_n = 1;
      @(posedge clk); #1;

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         in_valid   = $urandom_range(0, 3) != 0;
         out_ready  = $urandom_range(0, 2) != 0;
         flush      = $urandom_range(0, 15) == 0;
         resultado  = $urandom;
         rd         = RW'($urandom_range(0, 15));
         we         = 1'($urandom_range(0, 1));
         aluControl = 3'($urandom_range(0, 7));
         set_flags  = 1'($urandom_range(0, 1));
         {neg, zero, cout, overflow} = 4'($urandom_range(0, 15));
         cond       = 4'($urandom_range(0, 15));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
